tds_channel_readout_arbiter: RTL and testbench

- Downstream consumer of the 4-channel TDS channel-data block, in the clk160 domain.
- Round-robins across the four 120-bit channel FIFOs and drains bursts from eligible channels.
- Frames each burst as a packet of 32-bit words on a valid/ready stream toward the logger/Ethernet sender.

---
 rtl/tds_channel_readout_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_tds_channel_readout_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tds_channel_readout_arbiter.sv
// Round-robin readout of four 120-bit TDS channel FIFOs into packets of 32-bit stream beats.
// Define TDS_ARB_CHECKSUM_EN to append an XOR checksum trailer word to every packet.
module tds_channel_readout_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
    input  logic         clk160,
    input  logic         reset,
    input  logic [3:0]   enable,
    input  logic [3:0]   channel_linked,
    input  logic [3:0]   data_tran_stop,
    input  logic [3:0]   channel_fifo_empty,
    input  logic [39:0]  channel_data_counter,
    input  logic [479:0] channel_data,
    output logic [3:0]   channel_data_read,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [1:0]   cur_channel,
    output logic         busy,
    output logic [15:0]  pkt_count
);

`ifdef TDS_ARB_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, RD, CAP, SEND, TRL} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, RD, CAP, SEND} state_t;
`endif

    localparam logic [9:0] MAX_W = 10'(MAX_BURST);

    state_t       state, state_nxt;
    logic [1:0]   rr_ptr;
    logic [9:0]   len, words_sent;
    logic [1:0]   beat;
    logic [119:0] hold;
    logic         pkt_done;

    logic [3:0]   elig;
    logic         pick_found;
    logic [1:0]   pick_ch, idx;
    logic [9:0]   sel_cnt, len_nxt;
    logic [31:0]  hdr_word, beat_word;
    logic         last_word;

`ifdef TDS_ARB_CHECKSUM_EN
    logic [31:0]  csum;
`endif

    assign elig = enable & channel_linked & ~data_tran_stop & ~channel_fifo_empty;

    // Walk offsets high-to-low so the nearest eligible channel after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr_ptr;
        idx        = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (elig[idx]) begin
                pick_found = 1'b1;
                pick_ch    = idx;
            end
        end
    end

    // A non-empty FIFO reporting zero words still holds at least one.
    always_comb begin
        sel_cnt = channel_data_counter[10*pick_ch +: 10];
        if (sel_cnt == 10'd0)
            len_nxt = 10'd1;
        else if (sel_cnt > MAX_W)
            len_nxt = MAX_W;
        else
            len_nxt = sel_cnt;
    end

    assign hdr_word  = {HDR_MAGIC, 6'b0, cur_channel, 6'b0, len};
    assign last_word = ({1'b0, words_sent} + 11'd1) >= {1'b0, len};
    assign busy      = (state != IDLE);

    always_comb begin
        case (beat)
            2'd0:    beat_word = {8'h00, hold[119:96]};
            2'd1:    beat_word = hold[95:64];
            2'd2:    beat_word = hold[63:32];
            default: beat_word = hold[31:0];
        endcase
    end

    always_comb begin
        state_nxt         = state;
        out_valid         = 1'b0;
        out_data          = '0;
        out_last          = 1'b0;
        channel_data_read = '0;
        pkt_done          = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found)
                    state_nxt = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
                if (out_ready)
                    state_nxt = RD;
            end
            RD: begin
                channel_data_read = 4'b0001 << cur_channel;
                state_nxt         = CAP;
            end
            CAP: state_nxt = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_data  = beat_word;
`ifndef TDS_ARB_CHECKSUM_EN
                out_last  = last_word && (beat == 2'd3);
`endif
                if (out_ready && beat == 2'd3) begin
                    if (!last_word) begin
                        state_nxt = RD;
                    end else begin
`ifdef TDS_ARB_CHECKSUM_EN
                        state_nxt = TRL;
`else
                        state_nxt = IDLE;
                        pkt_done  = 1'b1;
`endif
                    end
                end
            end
`ifdef TDS_ARB_CHECKSUM_EN
            TRL: begin
                out_valid = 1'b1;
                out_data  = csum;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                    pkt_done  = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            cur_channel <= 2'd0;
            len         <= 10'd0;
            words_sent  <= 10'd0;
            beat        <= 2'd0;
            hold        <= '0;
            pkt_count   <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        cur_channel <= pick_ch;
                        len         <= len_nxt;
                        words_sent  <= 10'd0;
                        beat        <= 2'd0;
                    end
                end
                CAP: begin
                    hold <= channel_data[120*cur_channel +: 120];
                    beat <= 2'd0;
                end
                SEND: begin
                    if (out_ready) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3)
                            words_sent <= words_sent + 10'd1;
                    end
                end
                default: ;
            endcase
            if (pkt_done) begin
                rr_ptr    <= cur_channel + 2'd1;
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

`ifdef TDS_ARB_CHECKSUM_EN
    // Running XOR of header and data beats; the trailer itself is excluded.
    always_ff @(posedge clk160 or posedge reset) begin
        if (reset)
            csum <= '0;
        else if (state == IDLE)
            csum <= '0;
        else if (out_valid && out_ready && state != TRL)
            csum <= csum ^ out_data;
    end
`endif

endmodule

// File: tb/tb_tds_channel_readout_arbiter.sv
// Directed bench for tds_channel_readout_arbiter with a behavioural model of the four channel FIFOs.
module tb_tds_channel_readout_arbiter;

`ifdef TDS_ARB_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic         clk160 = 1'b0;
    logic         reset  = 1'b1;
    logic [3:0]   enable = 4'hF;
    logic [3:0]   channel_linked = 4'hF;
    logic [3:0]   data_tran_stop = 4'h0;
    logic [3:0]   channel_fifo_empty;
    logic [39:0]  channel_data_counter;
    logic [479:0] channel_data;
    logic [3:0]   channel_data_read;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic [1:0]   cur_channel;
    logic         busy;
    logic [15:0]  pkt_count;

    tds_channel_readout_arbiter #(.MAX_BURST(16), .HDR_MAGIC(8'hA5)) dut (
        .clk160(clk160), .reset(reset), .enable(enable), .channel_linked(channel_linked),
        .data_tran_stop(data_tran_stop), .channel_fifo_empty(channel_fifo_empty),
        .channel_data_counter(channel_data_counter), .channel_data(channel_data),
        .channel_data_read(channel_data_read), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .cur_channel(cur_channel),
        .busy(busy), .pkt_count(pkt_count)
    );

    always #3 clk160 = ~clk160;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word i of channel c: distinct, recognisable fields in every 32-bit beat.
    function automatic logic [119:0] word(input int c, input int i);
        logic [15:0] t;
        t = {8'(c), 8'(i)};
        return {8'h0A, 8'hB0 + 8'(c), 8'(i), 16'h1111, t, 16'h2222, t, 16'h3333, t};
    endfunction

    // FIFO model: data appears one cycle after the read pulse.
    int           cnt [4];
    int           rdi [4];
    logic [119:0] chan_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        assign channel_data[120*g +: 120]       = chan_data[g];
        assign channel_data_counter[10*g +: 10] = (cnt[g] > 1023) ? 10'd1023 : 10'(cnt[g]);
        assign channel_fifo_empty[g]            = (cnt[g] == 0);
    end

    always @(posedge clk160) begin
        for (int c = 0; c < 4; c++) begin
            if (channel_data_read[c]) begin
                chan_data[c] <= word(c, rdi[c]);
                rdi[c] = rdi[c] + 1;
                cnt[c] = cnt[c] - 1;
            end
        end
    end

    // Stream monitor: logs handshaken beats, read pulses, and checks stall stability.
    logic [32:0] beat_q [$];
    int          rd_pulses [4];
    int          rd_wide = 0;
    logic [3:0]  rd_prev = '0;
    logic        stall_prev = 1'b0;
    logic [32:0] stall_val = '0;

    always @(negedge clk160) begin
        if (reset) begin
            stall_prev = 1'b0;
            rd_prev    = '0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 128'(out_valid), 128'd1);
                chk("stall_hold", 128'({out_last, out_data}), 128'(stall_val));
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_last, out_data};
            if (out_valid && out_ready)
                beat_q.push_back({out_last, out_data});
            if ((channel_data_read & rd_prev) != 4'd0 || $countones(channel_data_read) > 1)
                rd_wide++;
            for (int c = 0; c < 4; c++)
                if (channel_data_read[c]) rd_pulses[c]++;
            rd_prev = channel_data_read;
        end
    end

    bit rnd_ready = 1'b0;

    task automatic step();
        @(posedge clk160);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_pkts(input int target, input int budget, input string tag);
        int n = 0;
        while (pkt_count != 16'(target) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 128'(pkt_count), 128'(target));
    endtask

    task automatic do_reset();
        @(posedge clk160);
        #1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        beat_q.delete();
    endtask

    task automatic expect_pkt(input int c, input int len, input int base);
        logic [32:0]  b;
        logic [31:0]  e, x;
        logic [119:0] w;
        logic         le;
        chk($sformatf("beats_ch%0d", c), 128'(beat_q.size() >= 1 + 4*len + CS), 128'd1);
        if (beat_q.size() < 1 + 4*len + CS) return;
        b = beat_q.pop_front();
        e = {8'hA5, 6'b0, 2'(c), 6'b0, 10'(len)};
        x = e;
        chk($sformatf("hdr_ch%0d", c), 128'(b), 128'({1'b0, e}));
        for (int i = 0; i < len; i++) begin
            w = word(c, base + i);
            for (int j = 0; j < 4; j++) begin
                case (j)
                    0:       e = {8'h00, w[119:96]};
                    1:       e = w[95:64];
                    2:       e = w[63:32];
                    default: e = w[31:0];
                endcase
                le = (i == len - 1) && (j == 3) && (CS == 0);
                x  = x ^ e;
                b  = beat_q.pop_front();
                chk($sformatf("data_ch%0d_w%0d_b%0d", c, i, j), 128'(b), 128'({le, e}));
            end
        end
`ifdef TDS_ARB_CHECKSUM_EN
        b = beat_q.pop_front();
        chk($sformatf("trailer_ch%0d", c), 128'(b), 128'({1'b1, x}));
`endif
    endtask

    logic [31:0] t1 [0:8];
    int          base [4];
    int          n;
    logic [31:0] x1;

    initial begin
        for (int c = 0; c < 4; c++) begin
            cnt[c] = 0; rdi[c] = 0; rd_pulses[c] = 0; chan_data[c] = '0;
        end
        t1 = '{32'hA5010002,
               32'h000AB100, 32'h11110100, 32'h22220100, 32'h33330100,
               32'h000AB101, 32'h11110101, 32'h22220101, 32'h33330101};

        // reset state
        repeat (3) @(posedge clk160);
        #1;
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_data", 128'(out_data), 128'd0);
        chk("rst_last", 128'(out_last), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_read", 128'(channel_data_read), 128'd0);
        chk("rst_cur", 128'(cur_channel), 128'd0);
        chk("rst_pkt", 128'(pkt_count), 128'd0);
        reset = 1'b0;

        // channel 1 alone, two words
        cnt[1] = 2;
        wait_pkts(1, 200, "t1_pkt_count");
        chk("t1_nbeats", 128'(beat_q.size()), 128'(9 + CS));
        x1 = '0;
        for (int k = 0; k < 9; k++) begin
            x1 = x1 ^ t1[k];
            if (beat_q.size() > 0)
                chk($sformatf("t1_beat%0d", k), 128'(beat_q.pop_front()),
                    128'({(k == 8) && (CS == 0), t1[k]}));
        end
`ifdef TDS_ARB_CHECKSUM_EN
        if (beat_q.size() > 0) chk("t1_trailer", 128'(beat_q.pop_front()), 128'({1'b1, x1}));
`endif
        chk("t1_reads", 128'(rd_pulses[1]), 128'd2);
        chk("t1_read_shape", 128'(rd_wide), 128'd0);

        // all four eligible, then wrap back to channel 0
        do_reset();
        chk("t2_pkt_after_reset", 128'(pkt_count), 128'd0);
        for (int c = 0; c < 4; c++) begin base[c] = rdi[c]; cnt[c] = 1; end
        wait_pkts(4, 400, "t2_pkts");
        for (int c = 0; c < 4; c++) expect_pkt(c, 1, base[c]);
        repeat (20) step();
        chk("t2_idle_busy", 128'(busy), 128'd0);
        chk("t2_idle_valid", 128'(out_valid), 128'd0);
        base[0] = rdi[0]; base[2] = rdi[2];
        cnt[0] = 1; cnt[2] = 1;
        wait_pkts(6, 400, "t2_wrap_pkts");
        expect_pkt(0, 1, base[0]);
        expect_pkt(2, 1, base[2]);

        // counter above MAX_BURST
        do_reset();
        base[2] = rdi[2];
        n = rd_pulses[2];
        cnt[2] = 40;
        wait_pkts(1, 400, "t3_pkt1");
        chk("t3_reads_pkt1", 128'(rd_pulses[2] - n), 128'd16);
        wait_pkts(3, 1200, "t3_pkts");
        expect_pkt(2, 16, base[2]);
        expect_pkt(2, 16, base[2] + 16);
        expect_pkt(2, 8, base[2] + 32);
        chk("t3_fifo_left", 128'(cnt[2]), 128'd0);

        // random backpressure
        do_reset();
        base[3] = rdi[3];
        cnt[3] = 3;
        rnd_ready = 1'b1;
        wait_pkts(1, 800, "t4_pkt");
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        expect_pkt(3, 3, base[3]);
        chk("t4_no_extra", 128'(beat_q.size()), 128'd0);

        // stop raised mid-packet; channel 0 then skipped while stop stays high
        do_reset();
        base[0] = rdi[0]; base[1] = rdi[1];
        n = rd_pulses[0];
        cnt[0] = 3; cnt[1] = 1;
        for (int k = 0; k < 100 && rd_pulses[0] == n; k++) step();
        chk("t5_started", 128'(rd_pulses[0] - n), 128'd1);
        repeat (3) step();
        data_tran_stop[0] = 1'b1;
        cnt[0] = cnt[0] + 2;
        wait_pkts(2, 400, "t5_pkts");
        repeat (40) step();
        chk("t5_skip_pkts", 128'(pkt_count), 128'd2);
        chk("t5_skip_busy", 128'(busy), 128'd0);
        expect_pkt(0, 3, base[0]);
        expect_pkt(1, 1, base[1]);

        // asynchronous reset during beat 2 of channel 1
        beat_q.delete();
        cnt[1] = 1;
        for (int k = 0; k < 100 && beat_q.size() < 3; k++) step();
        chk("t6_beats_before", 128'(beat_q.size()), 128'd3);
        reset = 1'b1;
        #1;
        chk("t6_valid", 128'(out_valid), 128'd0);
        chk("t6_data", 128'(out_data), 128'd0);
        chk("t6_last", 128'(out_last), 128'd0);
        chk("t6_busy", 128'(busy), 128'd0);
        chk("t6_cur", 128'(cur_channel), 128'd0);
        chk("t6_pkt", 128'(pkt_count), 128'd0);
        chk("t6_read", 128'(channel_data_read), 128'd0);
        n = 0;
        foreach (beat_q[k]) if (beat_q[k][32]) n++;
        chk("t6_no_last", 128'(n), 128'd0);
        step();
        reset = 1'b0;
        beat_q.delete();
        repeat (10) step();
        chk("t6_idle_after", 128'(busy), 128'd0);

`ifdef TDS_ARB_CHECKSUM_EN
        // single-word packet with trailer
        do_reset();
        base[2] = rdi[2];
        cnt[2] = 1;
        wait_pkts(1, 200, "t7_pkt");
        expect_pkt(2, 1, base[2]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
